// File: rtl/fixed_pkg.sv
// Shared fixed-point formats, derived widths and FSM states for the
// squarer and its companion square-root unit.
package fixed_pkg;

   localparam int IN_W     = 24;
   localparam int IN_FRAC  = 16;
   localparam int OUT_W    = 12;
   localparam int OUT_FRAC = 4;

   // Square of a Q8.16 value carries 2*IN_FRAC fraction bits; drop down to OUT_FRAC.
   localparam int SH    = 2*IN_FRAC - OUT_FRAC;
   localparam int ACC_W = 2*IN_W;
   localparam int R_W   = ACC_W - SH + 1;
   localparam int CNT_W = $clog2(IN_W);

   localparam logic [IN_W-1:0]  IN_ONE  = IN_W'(1) << IN_FRAC;
   localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1) << OUT_FRAC;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      ROUND,
      DONE
   } state_t;

endpackage

// File: rtl/sat_round.sv
// Rounds the full-precision square to Q8.4 (round half up) and saturates
// when the rounded value no longer fits in OUT_W bits.
module sat_round
   import fixed_pkg::*;
(
   input  logic [ACC_W-1:0] acc,
   output logic [OUT_W-1:0] y_next,
   output logic             ovf_next
);

   logic [R_W-1:0] r;
   logic           unused_low;

   // One spare bit on r keeps the rounding carry from wrapping.
   always_comb begin
      r        = {1'b0, acc[ACC_W-1:SH]} + R_W'(acc[SH-1]);
      ovf_next = |r[R_W-1:OUT_W];
      y_next   = ovf_next ? '1 : r[OUT_W-1:0];
   end

   assign unused_low = ^acc[SH-2:0];

endmodule

// File: rtl/fixed_square.sv
// Iterative shift-add squarer: Q8.16 in, rounded/saturated Q8.4 out,
// one partial product per cycle under a start/busy/done handshake.
module fixed_square
   import fixed_pkg::*;
(
   input  logic             clk,
   input  logic             rst_,
   input  logic             start,
   input  logic [IN_W-1:0]  x,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] y,
   output logic             overflow
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(IN_W-1);

   state_t             state;
   state_t             state_nxt;
   logic [IN_W-1:0]    mcand;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   i;
   logic [OUT_W-1:0]   y_stage;
   logic               ovf_stage;
   logic [OUT_W-1:0]   y_next;
   logic               ovf_next;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = MUL;
         MUL:     if (i == LAST_STEP) state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == MUL) || (state == ROUND);

   // Multiplier operand is also the multiplicand, so bit i of mcand
   // selects whether the shifted copy of itself joins the sum.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         mcand     <= '0;
         acc       <= '0;
         i         <= '0;
         y_stage   <= '0;
         ovf_stage <= 1'b0;
         y         <= '0;
         overflow  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) mcand <= x;
               acc <= '0;
               i   <= '0;
            end
            MUL: begin
               if (mcand[i]) acc <= acc + ({{IN_W{1'b0}}, mcand} << i);
               i <= i + 1'b1;
            end
            ROUND: begin
               y_stage   <= y_next;
               ovf_stage <= ovf_next;
            end
            DONE: begin
               y        <= y_stage;
               overflow <= ovf_stage;
               done     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   sat_round u_sat_round (
      .acc      (acc),
      .y_next   (y_next),
      .ovf_next (ovf_next)
   );

endmodule

// File: tb/tb_fixed_square.sv
// Directed-vector bench for fixed_square with hand-computed Q8.4 results.
module tb_fixed_square;

   logic        clk;
   logic        rst_;
   logic        start;
   logic [23:0] x;
   logic        busy;
   logic        done;
   logic [11:0] y;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   fixed_square dut (
      .clk      (clk),
      .rst_     (rst_),
      .start    (start),
      .x        (x),
      .busy     (busy),
      .done     (done),
      .y        (y),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts one operation and watches 40 edges after acceptance. Records the
   // edge count of the first done, the number of done pulses, and whether busy
   // matched the expected profile (high after edges 0..24, low afterwards).
   // A nonzero poke_at re-pulses start with another operand at that edge.
   task automatic run_op(input logic [23:0] x_val, input int poke_at,
                         output logic [11:0] y_obs, output logic ovf_obs,
                         output int lat, output int done_cnt, output bit busy_ok);
      lat      = 999;
      done_cnt = 0;
      busy_ok  = 1'b1;
      y_obs    = 12'hBAD;
      ovf_obs  = 1'bx;
      @(posedge clk); #1;
      x     = x_val;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      x     = 24'hABCDEF;
      if (busy !== 1'b1) busy_ok = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done === 1'b1) begin
            done_cnt++;
            if (lat == 999) begin
               lat     = n;
               y_obs   = y;
               ovf_obs = overflow;
            end
         end
         if (n <= 24 && busy !== 1'b1) busy_ok = 1'b0;
         if (n >= 25 && busy !== 1'b0) busy_ok = 1'b0;
         if (n == poke_at) begin
            start = 1'b1;
            x     = 24'h030000;
         end
      end
   endtask

   task automatic test_reset;
      rst_  = 1'b0;
      start = 1'b0;
      x     = '0;
      repeat (3) @(posedge clk);
      #1;
      checks += 4;
      if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      if (done !== 1'b0)     begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
      if (y !== 12'h000)     begin failures++; $display("[TB] FAIL reset_y got=%h exp=000", y); end
      if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", overflow); end
      rst_ = 1'b1;
   endtask

   task automatic test_basic;
      logic [11:0] yo; logic ov; int lat; int dc; bit bok;
      run_op(24'h020000, 0, yo, ov, lat, dc, bok);
      checks += 5;
      if (lat !== 26)    begin failures++; $display("[TB] FAIL two_latency got=%0d exp=26", lat); end
      if (yo !== 12'h040) begin failures++; $display("[TB] FAIL two_y got=%h exp=040", yo); end
      if (ov !== 1'b0)    begin failures++; $display("[TB] FAIL two_ovf got=%b exp=0", ov); end
      if (dc !== 1)       begin failures++; $display("[TB] FAIL two_done_count got=%0d exp=1", dc); end
      if (!bok)           begin failures++; $display("[TB] FAIL two_busy profile wrong exp=high for 25 cycles"); end
      run_op(24'h018000, 0, yo, ov, lat, dc, bok);
      checks += 3;
      if (yo !== 12'h024) begin failures++; $display("[TB] FAIL onehalf_y got=%h exp=024", yo); end
      if (ov !== 1'b0)    begin failures++; $display("[TB] FAIL onehalf_ovf got=%b exp=0", ov); end
      if (!bok)           begin failures++; $display("[TB] FAIL onehalf_busy profile wrong exp=high for 25 cycles"); end
      // y must hold between operations
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (y !== 12'h024)  begin failures++; $display("[TB] FAIL hold_y got=%h exp=024", y); end
   endtask

   task automatic test_rounding;
      logic [11:0] yo; logic ov; int lat; int dc; bit bok;
      run_op(24'h005A82, 0, yo, ov, lat, dc, bok);
      checks += 2;
      if (yo !== 12'h002) begin failures++; $display("[TB] FAIL round_up_y got=%h exp=002", yo); end
      if (ov !== 1'b0)    begin failures++; $display("[TB] FAIL round_up_ovf got=%b exp=0", ov); end
      run_op(24'h0FF000, 0, yo, ov, lat, dc, bok);
      checks += 2;
      if (yo !== 12'hFE0) begin failures++; $display("[TB] FAIL round_down_y got=%h exp=fe0", yo); end
      if (ov !== 1'b0)    begin failures++; $display("[TB] FAIL round_down_ovf got=%b exp=0", ov); end
   endtask

   task automatic test_saturation;
      logic [11:0] yo; logic ov; int lat; int dc; bit bok;
      run_op(24'h100000, 0, yo, ov, lat, dc, bok);
      checks += 2;
      if (yo !== 12'hFFF) begin failures++; $display("[TB] FAIL sat16_y got=%h exp=fff", yo); end
      if (ov !== 1'b1)    begin failures++; $display("[TB] FAIL sat16_ovf got=%b exp=1", ov); end
      run_op(24'h000000, 0, yo, ov, lat, dc, bok);
      checks += 2;
      if (yo !== 12'h000) begin failures++; $display("[TB] FAIL zero_y got=%h exp=000", yo); end
      if (ov !== 1'b0)    begin failures++; $display("[TB] FAIL zero_ovf got=%b exp=0", ov); end
      // rounding carry pushes 4095.99 up to 4096, which must saturate
      run_op(24'h0FFFFF, 0, yo, ov, lat, dc, bok);
      checks += 2;
      if (yo !== 12'hFFF) begin failures++; $display("[TB] FAIL carry_sat_y got=%h exp=fff", yo); end
      if (ov !== 1'b1)    begin failures++; $display("[TB] FAIL carry_sat_ovf got=%b exp=1", ov); end
      run_op(24'hFFFFFF, 0, yo, ov, lat, dc, bok);
      checks += 2;
      if (yo !== 12'hFFF) begin failures++; $display("[TB] FAIL max_y got=%h exp=fff", yo); end
      if (ov !== 1'b1)    begin failures++; $display("[TB] FAIL max_ovf got=%b exp=1", ov); end
   endtask

   task automatic test_start_ignored;
      logic [11:0] yo; logic ov; int lat; int dc; bit bok;
      run_op(24'h018000, 8, yo, ov, lat, dc, bok);
      checks += 3;
      if (yo !== 12'h024) begin failures++; $display("[TB] FAIL ignore_y got=%h exp=024", yo); end
      if (dc !== 1)       begin failures++; $display("[TB] FAIL ignore_done_count got=%0d exp=1", dc); end
      if (lat !== 26)     begin failures++; $display("[TB] FAIL ignore_latency got=%0d exp=26", lat); end
   endtask

   task automatic test_back_to_back;
      logic [11:0] yo; logic ov; int lat; int dc; bit bok;
      run_op(24'h010000, 0, yo, ov, lat, dc, bok);
      run_op(24'h020000, 0, yo, ov, lat, dc, bok);
      checks += 2;
      if (yo !== 12'h040) begin failures++; $display("[TB] FAIL b2b_y got=%h exp=040", yo); end
      if (lat !== 26)     begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=26", lat); end
   endtask

   task automatic test_reset_mid_op;
      logic [11:0] yo; logic ov; int lat; int dc; bit bok;
      int seen_done;
      // y currently 0x040 from the previous test, so a clear is observable
      @(posedge clk); #1;
      x     = 24'h100000;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_ = 1'b0;
      #1;
      checks += 4;
      if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
      if (done !== 1'b0)     begin failures++; $display("[TB] FAIL midrst_done got=%b exp=0", done); end
      if (y !== 12'h000)     begin failures++; $display("[TB] FAIL midrst_y got=%h exp=000", y); end
      if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL midrst_ovf got=%b exp=0", overflow); end
      repeat (2) @(posedge clk);
      #1;
      rst_ = 1'b1;
      seen_done = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin failures++; $display("[TB] FAIL midrst_stray_done got=%0d exp=0", seen_done); end
      run_op(24'h010000, 0, yo, ov, lat, dc, bok);
      checks += 3;
      if (yo !== 12'h010) begin failures++; $display("[TB] FAIL after_rst_y got=%h exp=010", yo); end
      if (ov !== 1'b0)    begin failures++; $display("[TB] FAIL after_rst_ovf got=%b exp=0", ov); end
      if (lat !== 26)     begin failures++; $display("[TB] FAIL after_rst_latency got=%0d exp=26", lat); end
   endtask

   initial begin
      $display("[TB] fixed_square directed tests");
      test_reset;
      test_basic;
      test_rounding;
      test_saturation;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid_op;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fixed_square.md
# fixed_square

Iterative fixed-point squarer: the inverse companion to the square-root unit. It takes an unsigned Q8.16 value (24 bits, 16 fractional) and returns its square in the 12-bit Q8.4 input format that the square-root unit consumes. The product is rounded and saturated. It uses one shift-add step per cycle under a start/busy/done handshake, and sits beside the square-root unit in the shading/normalisation datapath.

## Interface
- IN_W, 24, input width (unsigned)
- IN_FRAC, 16, input fractional bits
- OUT_W, 12, output width (unsigned)
- OUT_FRAC, 4, output fractional bits
- clk  input  1  clock, rising edge
- rst_  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- x  input  IN_W  operand; captured on the accepted start edge
- busy  output  1  high in MUL and ROUND states
- done  output  1  one-cycle pulse when y/overflow are updated
- y  output  OUT_W  rounded, saturated square
- overflow  output  1  square exceeded the y range; y saturated

## Operation
- States: IDLE, MUL, ROUND, DONE.
- IDLE:
  - On start=1, latch x into the multiplicand register `mcand` (IN_W bits).
  - Clear the accumulator `acc` (2*IN_W bits) and the step counter `i`.
  - Go to MUL.
- MUL, step i = 0..IN_W-1:
  - If mcand[i]=1, then acc <= acc + (mcand << i).
  - i <= i+1.
  - After the step with i = IN_W-1, go to ROUND.
- ROUND:
  - SH = 2*IN_FRAC − OUT_FRAC (28 at defaults).
  - r = (acc >> SH) + acc[SH-1] (round half up).
  - If r ≥ 2^OUT_W: y_next = all ones, ovf_next = 1. Otherwise y_next = r[OUT_W-1:0], ovf_next = 0.
  - Compute r at width 2*IN_W−SH+1 so the round carry cannot wrap.
  - Go to DONE.
- DONE:
  - Register y and overflow, pulse done.
  - Go to IDLE unconditionally.
- start outside IDLE is ignored: not queued, no effect on the operation in flight.
- x is don't-care except on the accepted start edge.
- y and overflow hold their value until the next DONE.
- An exact rounding tie (remainder = 2^(SH−1)) is arithmetically impossible at defaults, so no tie-break rule is needed.
- Reset values:
  - State returns to IDLE.
  - busy=0, done=0, y=0, overflow=0.
  - acc=0, mcand=0, i=0.
- Reset mid-operation aborts the computation with no done pulse. The first start after rst_ deasserts is accepted normally.

## Timing
- Start accepted at edge E0. busy is high from E0 through the edge that enters DONE.
- MUL occupies IN_W cycles, ROUND 1, DONE 1.
- y, overflow and done are all registered at edge E0+IN_W+2, i.e. E0+26 at defaults.
- done is high for exactly one cycle. The earliest next accepted start is the cycle after done (back in IDLE).
- Throughput: one result per IN_W+3 cycles.
- The critical path is one 2*IN_W-bit add. No combinational path exists from inputs to outputs.

## Structure
- Shared package fixed_pkg holds:
  - the format constants (IN_W, IN_FRAC, OUT_W, OUT_FRAC, and the derived SH);
  - the state enum typedef;
  - the fixed-point ONE constants shared with the square-root unit.
- One sub-module is natural: `sat_round`, purely combinational. It maps the 2*IN_W-bit acc to {y_next, ovf_next}, so the rounding and saturation rules are testable in isolation.
- The FSM, counter and accumulator live in `fixed_square`.

## Test plan
- x=0x020000 (2.0), start pulse → done exactly 26 cycles after acceptance, y=0x040 (4.0), overflow=0.
- x=0x018000 (1.5) → y=0x024 (2.25), overflow=0; busy high for the whole computation.
- x=0x005A82 (≈0.35355) → y=0x002; checks round-up against the truncated value 0x001.
- x=0x100000 (16.0) → y=0xFFF, overflow=1. Then x=0x000000 → y=0x000, overflow=0.
- Start re-pulsed with x=0x030000 during MUL → ignored; the result is still that of the first operand, and only one done is produced.
- rst_ asserted at step 10 of MUL → busy=0, done=0, y=0 immediately. Then start with x=0x010000 → y=0x010 after 26 cycles.
